// File: rtl/ram_req_ctrl.sv
// Valid/ready front end for the single-port synchronous ram block.
// Define RAM_REQ_CTRL_BE_EN for byte enables (partial writes via read-modify-write).
module ram_req_ctrl #(
  parameter int s = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [s-1:0] req_addr,
  input  logic [31:0]  req_wdata,
  input  logic [3:0]   req_be,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_rdata,
  output logic [s-1:0] ram_address,
  output logic         ram_write,
  output logic [31:0]  ram_dataIn,
  input  logic [31:0]  ram_dataOut
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RSP  = 3'd4;

  logic [2:0]   state;
  logic [s-1:0] addr_q;
  logic [31:0]  wdata_q;
  logic [31:0]  rdata_q;
  logic         write_q;
  logic [31:0]  merged;
  logic         full;

`ifdef RAM_REQ_CTRL_BE_EN
  logic [3:0] be_q;

  // Enabled bytes keep the new data, the rest come from the old word.
  always_comb begin
    merged = wdata_q;
    for (int i = 0; i < 4; i++) begin
      if (!be_q[i]) merged[8*i +: 8] = ram_dataOut[8*i +: 8];
    end
  end

  assign full = &req_be;
`else
  logic be_unused;

  assign be_unused = ^req_be;
  assign merged    = wdata_q;
  assign full      = 1'b1;
`endif

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RSP);
  assign rsp_rdata   = rdata_q;
  assign ram_address = addr_q;
  assign ram_dataIn  = wdata_q;
  assign ram_write   = (state == WR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
`ifdef RAM_REQ_CTRL_BE_EN
      be_q    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
`ifdef RAM_REQ_CTRL_BE_EN
            be_q    <= req_be;
`endif
            state   <= (req_write && full) ? WR : RD;
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (write_q) begin
            wdata_q <= merged;
            state   <= WR;
          end else begin
            rdata_q <= ram_dataOut;
            state   <= RSP;
          end
        end
        WR: state <= IDLE;
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl with a behavioural ram and a scoreboard of read data.
// Partial-write expectations follow RAM_REQ_CTRL_BE_EN.
module tb_ram_req_ctrl;

  localparam int S = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [S-1:0] req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_be = 4'hF;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [31:0]  rsp_rdata;
  logic [S-1:0] ram_address;
  logic         ram_write;
  logic [31:0]  ram_dataIn;
  logic [31:0]  ram_dataOut;

  int n_chk = 0;
  int n_fail = 0;

  bit [31:0] model [int];
  logic [31:0] exp_q [$];

  logic [31:0] mem [0:(1<<S)-1];

  typedef struct {
    bit          wr;
    logic [S-1:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          hold;
    bit          use_exp;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  ram_req_ctrl #(.s(S)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .ram_address(ram_address),
    .ram_write(ram_write),
    .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  // Behavioural single-port ram: registered read, cleared by reset.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < (1<<S); i++) mem[i] <= '0;
      ram_dataOut <= '0;
    end else begin
      if (ram_write) mem[ram_address] <= ram_dataIn;
      ram_dataOut <= mem[ram_address];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mrd(int a);
    return model.exists(a) ? model[a] : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic do_write(logic [S-1:0] a, logic [31:0] d, logic [3:0] be);
    int lat;
    int wcnt = 0;
    logic [31:0] old;
    bit part;
`ifdef RAM_REQ_CTRL_BE_EN
    part = (be != 4'hF);
`else
    part = 1'b0;
`endif
    lat = part ? 4 : 2;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    step();
    req_valid = 1'b0;
    chk("wr_addr", {20'h0, ram_address}, {20'h0, a});
    chk("wr_din", ram_dataIn, d);
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) step();
      wcnt += int'(ram_write);
      if (c == lat) chk("wr_ready", {31'h0, req_ready}, 32'h1);
      else chk("wr_busy", {31'h0, req_ready}, 32'h0);
    end
    chk("wr_pulse", wcnt, 1);
    old = mrd(int'(a));
    if (part) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) old[8*i +: 8] = d[8*i +: 8];
      model[int'(a)] = old;
    end else begin
      model[int'(a)] = d;
    end
  endtask

  task automatic do_read(logic [S-1:0] a, int hold, bit use_exp, logic [31:0] exp);
    logic [31:0] first;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    exp_q.push_back(use_exp ? exp : mrd(int'(a)));
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) step();
      if (c < 3) chk("rd_early", {31'h0, rsp_valid}, 32'h0);
      else chk("rd_valid", {31'h0, rsp_valid}, 32'h1);
    end
    first = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_data", rsp_rdata, first);
      chk("bp_busy", {31'h0, req_ready}, 32'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    if (exp_q.size() > 0) chk("rsp_data", rsp_rdata, exp_q.pop_front());
    step();
    chk("rsp_done", {31'h0, req_ready}, 32'h1);
    chk("rsp_clr", {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    tbl.push_back('{1, 12'h123, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0});
    tbl.push_back('{0, 12'h123, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF});
    tbl.push_back('{0, 12'h123, 32'h0, 4'hF, 5, 1, 32'hDEADBEEF});
    tbl.push_back('{1, 12'h010, 32'h11223344, 4'hF, 0, 0, 32'h0});
    tbl.push_back('{1, 12'h010, 32'hAABBCCDD, 4'b0101, 0, 0, 32'h0});
`ifdef RAM_REQ_CTRL_BE_EN
    tbl.push_back('{0, 12'h010, 32'h0, 4'hF, 0, 1, 32'h11BB33DD});
    tbl.push_back('{1, 12'h020, 32'h55667788, 4'hF, 0, 0, 32'h0});
    tbl.push_back('{1, 12'h020, 32'h00000000, 4'b0000, 0, 0, 32'h0});
    tbl.push_back('{0, 12'h020, 32'h0, 4'hF, 0, 1, 32'h55667788});
`else
    tbl.push_back('{0, 12'h010, 32'h0, 4'hF, 0, 1, 32'hAABBCCDD});
`endif

    rst = 1'b0;
    repeat (2) step();
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("rst_wr", {31'h0, ram_write}, 32'h0);
    chk("rst_addr", {20'h0, ram_address}, 32'h0);
    chk("rst_din", ram_dataIn, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    do_read(12'h005, 0, 1, 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].be);
      else do_read(tbl[i].addr, tbl[i].hold, tbl[i].use_exp, tbl[i].exp);
    end

    // Reset during CAP: the pending read must vanish.
    wait_ready();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 12'h123;
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mid_rst_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_rst_wr", {31'h0, ram_write}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    model.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_quiet", {31'h0, rsp_valid}, 32'h0);
    end
    do_read(12'h123, 0, 1, 32'h0);

    // Top of the address range, then wrap-neighbour independence.
    for (int i = 0; i < 8; i++)
      do_write(12'hFF8 + 12'(i), $urandom, 4'hF);
    for (int i = 0; i < 8; i++)
      do_read(12'hFF8 + 12'(i), 0, 0, 32'h0);
    do_write(12'h000, 32'hC0FFEE00, 4'hF);
    do_read(12'hFFF, 0, 0, 32'h0);
    do_read(12'h000, 0, 1, 32'hC0FFEE00);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
# ram_req_ctrl

Request/response front end for the single-port synchronous `ram` block. It accepts one read or write per valid/ready handshake, sequences the RAM port signals (`address`, `write`, `dataIn`), and captures the RAM's registered `dataOut` into a held response. With byte enables compiled in, partial writes become an internal read-modify-write. The block sits directly upstream of `ram`, between the datapath/bus master and the memory array.

## Interface
- `s`, default 12: address width; must equal the `s` of the attached `ram`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-low reset; the same net also drives `ram.rst`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  s  word address.
- `req_wdata`  in  32  write data.
- `req_be`  in  4  byte enables; bit i covers bits [8i+7:8i]. Used only with `RAM_REQ_CTRL_BE_EN`.
- `rsp_valid`  out  1  read data held on `rsp_rdata`.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  read data.
- `ram_address`  out  s  to `ram.address`.
- `ram_write`  out  1  to `ram.write`.
- `ram_dataIn`  out  32  to `ram.dataIn`.
- `ram_dataOut`  in  32  from `ram.dataOut`; valid one edge after the address is presented.

## Operation
- The FSM has five states: IDLE, RD, CAP, WR, RSP.
- `req_ready` = (state == IDLE). Only one operation is outstanding at a time.
- Accept is `req_valid & req_ready` at a rising edge. On accept, `addr_q`, `wdata_q`, `be_q` and `write_q` are latched.
- Output assignments:
  - `ram_address` = `addr_q` at all times.
  - `ram_dataIn` = `wdata_q`.
  - `ram_write` = (state == WR).
- Transitions from IDLE on accept:
  - Read goes to RD.
  - Full write (`be` = 4'b1111, or macro off) goes to WR.
  - Partial write (macro on, `be` ≠ 4'b1111) goes to RD.
- RD → CAP unconditionally. The RAM samples `addr_q` at this edge.
- CAP behaviour:
  - Read: `rdata_q` ← `ram_dataOut`, then go to RSP.
  - Partial write: per byte, `wdata_q` ← `be_q[i]` ? `wdata_q` byte : `ram_dataOut` byte, then go to WR.
- WR → IDLE. The RAM writes `wdata_q` at this edge.
- RSP: `rsp_valid` = 1 and `rsp_rdata` = `rdata_q`, held stable until `rsp_ready`. Go to IDLE on the edge where `rsp_ready` = 1.
- Writes produce no response.
- `be` = 4'b0000 with macro on: goes through RD/CAP/WR and writes back the unchanged word. No special case.
- Address range: no check is needed; all 2^s addresses are legal and there is no wrap logic.

## Timing
- Reset values: state = IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `ram_write` = 0, `ram_address` = 0, `ram_dataIn` = 0.
- Cycle numbering: cycle 0 is the cycle in which the accept edge occurs.
- Read:
  - RD in cycle 1, CAP in cycle 2.
  - `rsp_valid` rises in cycle 3.
  - Next accept is possible in the cycle after the `rsp_ready` handshake.
  - Minimum occupancy is 4 cycles.
- Full write: WR in cycle 1, `ram_write` high for exactly 1 cycle, `req_ready` high again in cycle 2.
- Partial write: RD in cycle 1, CAP in cycle 2, WR in cycle 3, `req_ready` high in cycle 4.
- Read-after-write to the same address returns the new data, because the write has completed before IDLE.
- `rsp_valid`, `rsp_rdata` and `req_ready` are registered-state decodes; there are no combinational paths from `req_*` or `rsp_ready`.
- Reset mid-operation (`rst` low at any edge):
  - The FSM returns to IDLE and any pending response is dropped.
  - `ram_write` is low in the following cycle.
  - The RAM contents are cleared by the shared reset, so an aborted write is irrelevant.
- `rsp_ready` outside RSP is ignored.
- `req_valid` while not ready is held off; the requester must keep the request stable.

## Configuration
- `RAM_REQ_CTRL_BE_EN` defined:
  - Byte-enable path compiled in, including partial-write RMW through RD/CAP/WR and the merge logic.
- `RAM_REQ_CTRL_BE_EN` undefined:
  - `req_be` is ignored and `be_q`/merge logic is absent.
  - Every write is full-word: IDLE→WR→IDLE, 2 cycles.

## Test plan
- Reset then idle: hold `rst` = 0 for 2 cycles, release → `req_ready` = 1, `rsp_valid` = 0, `ram_write` = 0; a read of addr 0x005 returns 0x00000000.
- Write/read: write 0xDEADBEEF to 0x123, then read 0x123 → `ram_write` high for exactly 1 cycle; `rsp_valid` in cycle 3 after the read accept with `rsp_rdata` = 0xDEADBEEF.
- Backpressure: read 0x123 with `rsp_ready` held 0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable, `req_ready` = 0 throughout; handshake on cycle 6 → `req_ready` = 1 next cycle.
- Partial write (macro on): 0x11223344 at 0x010, then write 0xAABBCCDD with `be` = 4'b0101 → a later read returns 0x11BB33DD; `req_ready` returns 4 cycles after accept. Macro off: the same sequence returns 0xAABBCCDD.
- Reset mid-read: assert `rst` = 0 in the CAP cycle → next cycle IDLE, `rsp_valid` = 0, no response is ever issued.
- Back-to-back: 8 writes to addresses 0xFF8–0xFFF (top of the range), then 8 reads → all data matches; addresses 0xFFF and 0x000 are independent.
